dec_scan: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable; next generation of the team's 3-to-8 decoder blocks.
- Two modes:
  - Direct: registered decode of `in`.
  - Scan: an internal index walks the one-hot output across all 2^N lines, with a programmable dwell per line.
- Drives digit/row select for multiplexed displays and keypads, and sequences one-hot enables for downstream lab blocks.

---
 rtl/dec_scan.sv | 107 ++++++++++
 tb/tb_dec_scan.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot decoder with direct and dwell-timed scan modes.
// Optional `DEC_SCAN_DIR_EN adds a `dir` input for downward scanning.
module dec_scan #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned HOLD_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
`ifdef DEC_SCAN_DIR_EN
    input  logic                dir,
`endif
    input  logic [IN_W-1:0]     in,
    input  logic [HOLD_W-1:0]   dwell,
    output logic [2**IN_W-1:0]  out,
    output logic [IN_W-1:0]     idx,
    output logic                wrap
);

    localparam int unsigned OUT_W = 2 ** IN_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIRECT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IN_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              scan_down;

`ifdef DEC_SCAN_DIR_EN
    assign scan_down = dir;
`else
    assign scan_down = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (!mode) begin
                        state_d = DIRECT;
                        idx_d   = in;
                        cnt_d   = '0;
                    end else if (cnt_q >= dwell) begin
                        // Advance even if dwell was lowered below cnt, so the counter never stalls.
                        cnt_d = '0;
                        if (scan_down) begin
                            idx_d  = idx_q - 1'b1;
                            wrap_d = (idx_q == '0);
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            wrap_d = (idx_q == '1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DIRECT share entry behaviour: load idx from in.
                    state_d = mode ? SCAN : DIRECT;
                    idx_d   = in;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_d = '0;
        if (state_d != IDLE) begin
            out_d = OUT_W'(1) << idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Self-checking bench for dec_scan: directed steps plus randomized traffic
// compared against an arithmetic reference model.
module tb_dec_scan;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] in = 3'd0;
    logic [3:0] dwell = 4'd0;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: 0 idle, 1 direct, 2 scan
    int m_st = 0;
    int m_idx = 0;
    int m_cnt = 0;
    int m_wrap = 0;

    dec_scan #(.IN_W(3), .HOLD_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
`ifdef DEC_SCAN_DIR_EN
        .dir   (dir),
`endif
        .in    (in),
        .dwell (dwell),
        .out   (out),
        .idx   (idx),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_out();
        logic [7:0] v;
        v = 8'h00;
        if (m_st != 0) v = 8'(1 << m_idx);
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_cnt = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        int down;
`ifdef DEC_SCAN_DIR_EN
        down = int'(dir);
`else
        down = 0;
`endif
        m_wrap = 0;
        if (rst) begin
            model_reset();
        end else if (!en) begin
            model_reset();
        end else if (m_st != 2) begin
            m_st = mode ? 2 : 1;
            m_idx = int'(in);
            m_cnt = 0;
        end else if (!mode) begin
            m_st = 1;
            m_idx = int'(in);
            m_cnt = 0;
        end else if (m_cnt >= int'(dwell)) begin
            m_cnt = 0;
            if (down != 0) begin
                m_wrap = (m_idx == 0) ? 1 : 0;
                m_idx = (m_idx + N - 1) % N;
            end else begin
                m_wrap = (m_idx == N - 1) ? 1 : 0;
                m_idx = (m_idx + 1) % N;
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (out === exp_out()) else begin
            miscompares++;
            $error("FAIL %s out: got %h expected %h", tag, out, exp_out());
        end
        vectors++;
        assert (idx === 3'(m_idx)) else begin
            miscompares++;
            $error("FAIL %s idx: got %0d expected %0d", tag, idx, m_idx);
        end
        vectors++;
        assert (wrap === 1'(m_wrap)) else begin
            miscompares++;
            $error("FAIL %s wrap: got %b expected %0d", tag, wrap, m_wrap);
        end
        vectors++;
        assert ($onehot0(out)) else begin
            miscompares++;
            $error("FAIL %s onehot0: got %h expected at most one bit set", tag, out);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic lit(input string tag, input logic [7:0] eo, input logic ew);
        vectors++;
        assert (out === eo && wrap === ew) else begin
            miscompares++;
            $error("FAIL %s: got out=%h wrap=%b expected out=%h wrap=%b", tag, out, wrap, eo, ew);
        end
    endtask

    logic [7:0] seq_out [10] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80,
                                 8'h01, 8'h01, 8'h01, 8'h02};
    logic       seq_wrap [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [4:0] combo;

    initial begin
        // Reset visible before any clock edge
        #2 rst = 1'b1;
        #1 model_reset();
        check("reset_async");
        tick("reset_held");
        #2 rst = 1'b0;

        // Direct sweep
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            in = 3'(i);
            tick("direct_sweep");
            lit("direct_literal", 8'(1 << i), 1'b0);
        end

        // Enable gating over all {en,in}
        for (int i = 0; i < 16; i++) begin
            combo = 5'(i);
            en = combo[3];
            in = combo[2:0];
            tick("en_gate");
        end

        // Scan dwell=2 from 6 (dwell sampled at the entry edge is irrelevant: cnt starts at 0)
        en = 1'b0; tick("pre_scan_idle");
        en = 1'b1; mode = 1'b1; dwell = 4'd2; in = 3'd6;
        for (int i = 0; i < 10; i++) begin
            tick("scan_d2");
            in = 3'(i);
            lit("scan_d2_literal", seq_out[i], seq_wrap[i]);
        end

        // Scan dwell=0: two full sweeps
        dwell = 4'd0;
        for (int i = 0; i < 2 * N; i++) tick("scan_d0");

        // Async reset mid-dwell
        dwell = 4'd5;
        tick("scan_d5");
        tick("scan_d5");
        #2 rst = 1'b1;
        #1 model_reset();
        check("rst_mid_dwell");
        lit("rst_mid_dwell_literal", 8'h00, 1'b0);
        #2 rst = 1'b0;
        tick("after_rst");
        tick("after_rst");

        // en drop during scan, re-enter, then mode 1->0 with in=3
        en = 1'b0; tick("en_drop");
        lit("en_drop_literal", 8'h00, 1'b0);
        en = 1'b1; in = 3'd5; tick("rescan");
        tick("rescan");
        mode = 1'b0; in = 3'd3; tick("scan_to_direct");
        lit("scan_to_direct_literal", 8'h08, 1'b0);

`ifdef DEC_SCAN_DIR_EN
        // Downward scan from 1
        en = 1'b0; tick("dir_idle");
        en = 1'b1; mode = 1'b1; dwell = 4'd0; dir = 1'b1; in = 3'd1;
        tick("dir_down"); lit("dir_down_lit0", 8'h02, 1'b0);
        tick("dir_down"); lit("dir_down_lit1", 8'h01, 1'b0);
        tick("dir_down"); lit("dir_down_lit2", 8'h80, 1'b1);
        tick("dir_down"); lit("dir_down_lit3", 8'h40, 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 15) != 0);
            mode = ($urandom_range(0, 7) != 0) ? mode : ~mode;
            in = 3'($urandom);
            dwell = 4'($urandom_range(0, 4));
`ifdef DEC_SCAN_DIR_EN
            dir = 1'($urandom);
`endif
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
